nec_ir_tx: RTL
==============

NEC_IR_TX -- requirements
Module: nec_ir_tx

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 28125, meaning clocks per 562.5 us NEC unit T at 50 MHz.
REQ-002 The block SHALL have parameter CARRIER_CYCLES, default 1316, meaning clocks per 38 kHz carrier period.
REQ-003 The block SHALL have parameter CARRIER_HIGH, default 438, meaning carrier high clocks per period; legal range 1..CARRIER_CYCLES-1.
REQ-004 The block SHALL have parameter GAP_UNITS, default 72, meaning post-frame silence in T.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port valid, input, 1 bit: frame request.
REQ-008 The block SHALL have port ready, output, 1 bit: idle and able to accept a request.
REQ-009 The block SHALL have port rpt, input, 1 bit: when high at handshake, send a repeat code instead of a full frame.
REQ-010 The block SHALL have port address, input, 16 bits: NEC address, low byte sent first.
REQ-011 The block SHALL have port command, input, 8 bits: NEC command.
REQ-012 The block SHALL have port ir_env, output, 1 bit: unmodulated envelope, 1 during mark.
REQ-013 The block SHALL have port ir_tx, output, 1 bit: carrier-modulated LED drive.

Function
REQ-014 A handshake SHALL occur on a rising edge with valid=1 and ready=1; rpt, address and command SHALL be captured on that edge, and later input changes SHALL NOT affect the frame.
REQ-015 ready SHALL be 1 only in IDLE; valid outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-016 States SHALL be IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, RPT_SPACE, STOP_MARK and GAP.
REQ-017 The first cycle after the handshake SHALL be in LEAD_MARK with ir_env=1, giving one-cycle latency.
REQ-018 Full-frame sequence: LEAD_MARK 16T, LEAD_SPACE 8T, then 32 × (BIT_MARK 1T, BIT_SPACE 1T for 0 or 3T for 1), STOP_MARK 1T, GAP GAP_UNITS×T, then IDLE.
REQ-019 The bit order SHALL be the 32-bit word {~command, command, address[15:8], address[7:0]} sent LSB first; the bit index is a 5-bit counter, and after bit 31's space the state SHALL go to STOP_MARK.
REQ-020 Repeat sequence: LEAD_MARK 16T, RPT_SPACE 4T, STOP_MARK 1T, GAP, then IDLE.
REQ-021 Each state SHALL last exactly N×UNIT_CYCLES clocks; the unit counter SHALL wrap at UNIT_CYCLES-1 and the state-duration counter SHALL count units.
REQ-022 ir_env SHALL be 1 exactly in LEAD_MARK, BIT_MARK and STOP_MARK.
REQ-023 ir_tx SHALL equal ir_env AND carrier; carrier SHALL be 1 for the first CARRIER_HIGH clocks of each CARRIER_CYCLES period.
REQ-024 The carrier phase SHALL restart at 0 on the first cycle of every mark state.
REQ-025 ir_tx SHALL be 0 whenever ir_env=0.
REQ-026 The next request SHALL be accepted on the cycle ready returns to 1, with no extra dead cycle.

Reset
REQ-027 rst=1 SHALL, on the next edge, force state=IDLE, ready=1, ir_env=0, ir_tx=0, and clear all counters and the shift register.
REQ-028 Reset mid-frame SHALL abort the frame with no stop mark and no gap.
REQ-029 rst SHALL take priority over a simultaneous valid.

Structure
REQ-030 Package ir_pkg SHALL hold the state enum and the unit-count constants (16, 8, 4, 3, 1) for shared use with the receive side.
REQ-031 Sub-module ir_carrier SHALL be the carrier generator, with clk, rst, sync (phase restart) and carrier ports.

Verification
(All scenarios use UNIT_CYCLES=10, CARRIER_CYCLES=4, CARRIER_HIGH=1, GAP_UNITS=72; handshake edge = cycle 0.)
REQ-032 The bench SHALL cover: address=16'h0000, command=8'h02, rpt=0 -> ir_env high cycles 1-160; 32 bits with 8 ones (80T); ir_env last high in STOP_MARK ending cycle 1050; ready=1 at cycle 1771.
REQ-033 The bench SHALL cover: decoded ir_env pulse widths for address=16'h5AA5, command=8'hC3 -> the receiver model returns 32'h3CC3_5AA5.
REQ-034 The bench SHALL cover: rpt=1 -> mark 160 cycles, space 40, mark 10, ready=1 at cycle 931.
REQ-035 The bench SHALL cover: valid held high continuously -> exactly one handshake per 1770-cycle frame; command changed mid-frame is not transmitted.
REQ-036 The bench SHALL cover: rst pulsed at cycle 500 -> next cycle ir_env=0, ir_tx=0, ready=1; a new request then starts a clean leader.
REQ-037 The bench SHALL cover: ir_tx during any mark shows pattern 1,0,0,0 from the mark's first cycle, and ir_tx is never 1 while ir_env=0.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared NEC IR definitions: FSM state encoding, frame timing in units of T,
// and the 32-bit frame word layout (used by both transmit and receive sides).
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        RPT_SPACE  = 3'd5,
        STOP_MARK  = 3'd6,
        GAP        = 3'd7
    } ir_state_e;

    localparam int LEAD_MARK_UNITS  = 16;
    localparam int LEAD_SPACE_UNITS = 8;
    localparam int RPT_SPACE_UNITS  = 4;
    localparam int ONE_SPACE_UNITS  = 3;
    localparam int BIT_UNITS        = 1;

    // Wire order of an NEC frame; bit 0 is transmitted first.
    function automatic logic [31:0] nec_word(input logic [15:0] address, input logic [7:0] command);
        return {~command, command, address};
    endfunction

endpackage

// File: rtl/ir_carrier.sv
// Carrier generator: high for the first CARRIER_HIGH clocks of each
// CARRIER_CYCLES period; sync forces phase 0 on the following cycle.
module ir_carrier #(
    parameter int CARRIER_CYCLES = 1316,
    parameter int CARRIER_HIGH   = 438
) (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic carrier
);

    localparam int PW = $clog2(CARRIER_CYCLES + 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;
    logic          carrier_q;

    // Next carrier phase: restart on sync, otherwise wrap at the period end.
    always_comb begin
        phase_d = PW'(0);
        if (sync) begin
            phase_d = PW'(0);
        end else if (phase_q == PW'(CARRIER_CYCLES - 1)) begin
            phase_d = PW'(0);
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    // Phase counter and registered carrier level.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PW'(0);
            carrier_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            carrier_q <= (phase_d < PW'(CARRIER_HIGH));
        end
    end

    assign carrier = carrier_q;

endmodule

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: sends a full 32-bit frame or a repeat code as a
// timed mark/space envelope, and drives the LED with the envelope-gated carrier.
module nec_ir_tx
    import ir_pkg::*;
#(
    parameter int UNIT_CYCLES    = 28125,
    parameter int CARRIER_CYCLES = 1316,
    parameter int CARRIER_HIGH   = 438,
    parameter int GAP_UNITS      = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    output logic        ready,
    input  logic        rpt,
    input  logic [15:0] address,
    input  logic [7:0]  command,
    output logic        ir_env,
    output logic        ir_tx
);

    localparam int UCW  = $clog2(UNIT_CYCLES + 1);
    localparam int MAXU = (GAP_UNITS > LEAD_MARK_UNITS) ? GAP_UNITS : LEAD_MARK_UNITS;
    localparam int DW   = $clog2(MAXU + 1);

    ir_state_e      state_q;
    logic [UCW-1:0] unit_cnt_q;
    logic [DW-1:0]  units_q;
    logic [4:0]     bit_idx_q;
    logic [31:0]    shift_q;
    logic           rpt_q;
    logic           ready_q;
    logic           env_q;

    logic [DW-1:0]  dur_s;
    logic           unit_last_s;
    logic           state_last_s;
    logic           sync_s;
    logic           carrier_s;

    // Duration of the current state in units, end-of-state detect, and the
    // carrier phase restart on every transition into a mark state.
    always_comb begin
        dur_s = DW'(BIT_UNITS);
        case (state_q)
            LEAD_MARK:  dur_s = DW'(LEAD_MARK_UNITS);
            LEAD_SPACE: dur_s = DW'(LEAD_SPACE_UNITS);
            BIT_SPACE:  dur_s = shift_q[0] ? DW'(ONE_SPACE_UNITS) : DW'(BIT_UNITS);
            RPT_SPACE:  dur_s = DW'(RPT_SPACE_UNITS);
            GAP:        dur_s = DW'(GAP_UNITS);
            default:    dur_s = DW'(BIT_UNITS);
        endcase
        unit_last_s  = (unit_cnt_q == UCW'(UNIT_CYCLES - 1));
        state_last_s = unit_last_s && (units_q == dur_s - DW'(1));
        if (state_q == IDLE) begin
            sync_s = valid;
        end else if (state_last_s && ((state_q == LEAD_SPACE) || (state_q == BIT_SPACE) ||
                                      (state_q == RPT_SPACE))) begin
            sync_s = 1'b1;
        end else begin
            sync_s = 1'b0;
        end
    end

    // Frame sequencer with registered ready/envelope outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            unit_cnt_q <= UCW'(0);
            units_q    <= DW'(0);
            bit_idx_q  <= 5'd0;
            shift_q    <= 32'd0;
            rpt_q      <= 1'b0;
            ready_q    <= 1'b1;
            env_q      <= 1'b0;
        end else if (state_q == IDLE) begin
            if (valid) begin
                state_q    <= LEAD_MARK;
                shift_q    <= nec_word(address, command);
                rpt_q      <= rpt;
                bit_idx_q  <= 5'd0;
                unit_cnt_q <= UCW'(0);
                units_q    <= DW'(0);
                ready_q    <= 1'b0;
                env_q      <= 1'b1;
            end else begin
                ready_q    <= 1'b1;
                env_q      <= 1'b0;
            end
        end else if (!unit_last_s) begin
            unit_cnt_q <= unit_cnt_q + UCW'(1);
        end else if (!state_last_s) begin
            unit_cnt_q <= UCW'(0);
            units_q    <= units_q + DW'(1);
        end else begin
            unit_cnt_q <= UCW'(0);
            units_q    <= DW'(0);
            case (state_q)
                LEAD_MARK: begin
                    state_q <= rpt_q ? RPT_SPACE : LEAD_SPACE;
                    env_q   <= 1'b0;
                end
                LEAD_SPACE: begin
                    state_q <= BIT_MARK;
                    env_q   <= 1'b1;
                end
                BIT_MARK: begin
                    state_q <= BIT_SPACE;
                    env_q   <= 1'b0;
                end
                BIT_SPACE: begin
                    shift_q   <= shift_q >> 1;
                    bit_idx_q <= bit_idx_q + 5'd1;
                    state_q   <= (bit_idx_q == 5'd31) ? STOP_MARK : BIT_MARK;
                    env_q     <= 1'b1;
                end
                RPT_SPACE: begin
                    state_q <= STOP_MARK;
                    env_q   <= 1'b1;
                end
                STOP_MARK: begin
                    state_q <= GAP;
                    env_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    env_q   <= 1'b0;
                end
            endcase
        end
    end

    ir_carrier #(
        .CARRIER_CYCLES(CARRIER_CYCLES),
        .CARRIER_HIGH  (CARRIER_HIGH)
    ) u_carrier (
        .clk    (clk),
        .rst    (rst),
        .sync   (sync_s),
        .carrier(carrier_s)
    );

    // Both operands are flops; the gate keeps the carrier phase aligned with the mark start.
    assign ready  = ready_q;
    assign ir_env = env_q;
    assign ir_tx  = env_q & carrier_s;

endmodule
